// File: rtl/dbg_cmd_master_if.sv
// Debug bus between the command master (debugger side) and the debug target.
// The master modport drives the command fields; the slave modport returns done/read data.
interface dbg_intf;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data_dbg_dut;
    logic        dut_done;
    logic [31:0] data_dut_dbg;

    modport master (
        output cmd,
        output addr,
        output data_dbg_dut,
        input  dut_done,
        input  data_dut_dbg
    );

    modport slave (
        input  cmd,
        input  addr,
        input  data_dbg_dut,
        output dut_done,
        output data_dut_dbg
    );
endinterface

// File: rtl/dbg_cmd_master.sv
// Debug command master: accepts one request, runs it on the debug bus, returns one response.
// Optional ACTIVE-state timeout is enabled with the DBG_TIMEOUT_EN macro.
module dbg_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_cmd_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    dbg_intf.master     dbg_bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rspData_q, rspData_d;
    logic        rspErr_q, rspErr_d;
    logic        cmdLegal;
    logic        cmdIsRead;
    logic        timeout;

    assign cmdLegal  = (req_cmd_i >= 8'h01) && (req_cmd_i <= 8'h06);
    assign cmdIsRead = (cmd_q == 8'h03) || (cmd_q == 8'h05);

`ifdef DBG_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmoCnt_q, tmoCnt_d;

    assign timeout = (tmoCnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside ACTIVE, so every command starts from zero.
    always_comb begin
        tmoCnt_d = '0;
        if (state_q == ACTIVE) begin
            tmoCnt_d = tmoCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            tmoCnt_q <= '0;
        end else begin
            tmoCnt_q <= tmoCnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rspData_d   = rspData_q;
        rspErr_d    = rspErr_q;
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rspData_d = '0;
                    if (cmdLegal) begin
                        cmd_d    = req_cmd_i;
                        addr_d   = req_addr_i;
                        wdata_d  = req_data_i;
                        rspErr_d = 1'b0;
                        state_d  = ACTIVE;
                    end else begin
                        rspErr_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            ACTIVE: begin
                if (dbg_bus.dut_done) begin
                    rspData_d = cmdIsRead ? dbg_bus.data_dut_dbg : '0;
                    rspErr_d  = 1'b0;
                    cmd_d     = '0;
                    addr_d    = '0;
                    wdata_d   = '0;
                    state_d   = DRAIN;
                end else if (timeout) begin
                    rspData_d = '0;
                    rspErr_d  = 1'b1;
                    cmd_d     = '0;
                    addr_d    = '0;
                    wdata_d   = '0;
                    state_d   = DRAIN;
                end
            end
            // Wait for the target to release done so it cannot complete the next command.
            DRAIN: begin
                if (!dbg_bus.dut_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rspData_q <= '0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rspData_q <= rspData_d;
            rspErr_q  <= rspErr_d;
        end
    end

    assign busy_o               = (state_q != IDLE);
    assign rsp_data_o           = rspData_q;
    assign rsp_err_o            = rspErr_q;
    assign dbg_bus.cmd          = cmd_q;
    assign dbg_bus.addr         = addr_q;
    assign dbg_bus.data_dbg_dut = wdata_q;

endmodule

// File: tb/tb_dbg_cmd_master.sv
// Scoreboard bench for dbg_cmd_master: directed commands push expected responses,
// a monitor pops and compares each accepted response.
module tb_dbg_cmd_master;

    logic        clk;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_cmd_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;

    dbg_intf dbg ();

    dbg_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cmd_i   (req_cmd_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .dbg_bus     (dbg)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every response taken by the consumer is compared against the queue head.
    always @(negedge clk) begin
        if (rstn_i === 1'b1 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rsp_unexpected actual=data %h err %b required=no response",
                         rsp_data_o, rsp_err_o);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("rsp_data", rsp_data_o, e.data);
                checkOutput("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                                 input logic [31:0] data, input bit expectRsp,
                                 input logic [31:0] expData, input logic expErr);
        int n;
        exp_t e;
        if (expectRsp) begin
            e.data = expData;
            e.err  = expErr;
            expQ.push_back(e);
        end
        @(negedge clk);
        req_valid_i = 1'b1;
        req_cmd_i   = cmd;
        req_addr_i  = addr;
        req_data_i  = data;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_seen", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_cmd_i   = 8'hFF;
        req_addr_i  = 32'hFFFF_FFFF;
        req_data_i  = 32'hA5A5_A5A5;
    endtask

    // Target model: called at the first ACTIVE negedge, asserts done after 'delay' cycles
    // and holds it 'hold' extra cycles into DRAIN.
    task automatic targetServe(input logic [7:0] expCmd, input logic [31:0] expAddr,
                               input logic [31:0] expWdata, input int delay,
                               input logic [31:0] rdata, input int hold);
        checkOutput("bus_cmd", {24'd0, dbg.cmd}, {24'd0, expCmd});
        checkOutput("bus_addr", dbg.addr, expAddr);
        checkOutput("bus_wdata", dbg.data_dbg_dut, expWdata);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("bus_cmd_stable", {24'd0, dbg.cmd}, {24'd0, expCmd});
            checkOutput("bus_wdata_stable", dbg.data_dbg_dut, expWdata);
        end
        dbg.data_dut_dbg = rdata;
        dbg.dut_done     = 1'b1;
        @(negedge clk);
        checkOutput("bus_cmd_dropped", {24'd0, dbg.cmd}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("drain_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
            checkOutput("drain_cmd_zero", {24'd0, dbg.cmd}, 32'd0);
        end
        dbg.dut_done     = 1'b0;
        dbg.data_dut_dbg = 32'hCAFE_0000;
        @(negedge clk);
        checkOutput("rsp_valid_after_drain", {31'd0, rsp_valid_o}, 32'd1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data_o, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_bus_cmd", {24'd0, dbg.cmd}, 32'd0);
        checkOutput("rst_bus_addr", dbg.addr, 32'd0);
        checkOutput("rst_bus_wdata", dbg.data_dbg_dut, 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    initial begin
        rstn_i           = 1'b1;
        req_valid_i      = 1'b0;
        req_cmd_i        = 8'h00;
        req_addr_i       = 32'd0;
        req_data_i       = 32'd0;
        rsp_ready_i      = 1'b1;
        dbg.dut_done     = 1'b0;
        dbg.data_dut_dbg = 32'd0;

        resetPulse();

        // Read pc, done two cycles in; consumer stalls the response for two cycles.
        rsp_ready_i = 1'b0;
        applyStimulus(8'h05, 32'h0000_0003, 32'h1234_5678, 1'b1, 32'h0000_0124, 1'b0);
        targetServe(8'h05, 32'h0000_0003, 32'h1234_5678, 2, 32'h0000_0124, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rsp_hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            checkOutput("rsp_hold_data", rsp_data_o, 32'h0000_0124);
        end
        rsp_ready_i = 1'b1;
        waitIdle();

        // Write reg: read data from the target must not leak into the response.
        applyStimulus(8'h04, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
        targetServe(8'h04, 32'h0000_0005, 32'hDEAD_BEEF, 3, 32'h55AA_55AA, 0);
        waitIdle();

        // Illegal code: straight to RESP with error, bus untouched.
        applyStimulus(8'h09, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0, 1'b1);
        checkOutput("bad_cmd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        checkOutput("bad_cmd_err", {31'd0, rsp_err_o}, 32'd1);
        checkOutput("bad_cmd_bus", {24'd0, dbg.cmd}, 32'd0);
        waitIdle();

        applyStimulus(8'h00, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        checkOutput("zero_cmd_err", {31'd0, rsp_err_o}, 32'd1);
        waitIdle();

        // Read reg with done held 3 cycles past cmd drop, then a halt on its own done.
        applyStimulus(8'h03, 32'h0000_001F, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);
        targetServe(8'h03, 32'h0000_001F, 32'h0, 0, 32'h0BAD_F00D, 3);
        waitIdle();
        applyStimulus(8'h01, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        targetServe(8'h01, 32'h0, 32'h0, 1, 32'h1111_1111, 0);
        waitIdle();

        // Silent target.
        applyStimulus(8'h02, 32'h0000_0007, 32'h0000_0009, `ifdef DBG_TIMEOUT_EN 1'b1 `else 1'b0 `endif,
                      32'h0, 1'b1);
`ifdef DBG_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) @(negedge clk);
        checkOutput("tmo_still_active", {24'd0, dbg.cmd}, 32'h02);
        @(negedge clk);
        checkOutput("tmo_cmd_dropped", {24'd0, dbg.cmd}, 32'd0);
        checkOutput("tmo_no_rsp_yet", {31'd0, rsp_valid_o}, 32'd0);
        @(negedge clk);
        checkOutput("tmo_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        checkOutput("tmo_rsp_err", {31'd0, rsp_err_o}, 32'd1);
        waitIdle();
        applyStimulus(8'h03, 32'h0000_0002, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_busy", {31'd0, busy_o}, 32'd1);
`else
        repeat (40) @(negedge clk);
        checkOutput("stuck_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("stuck_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        checkOutput("stuck_cmd", {24'd0, dbg.cmd}, 32'h02);
`endif
        resetPulse();
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_reset_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end

        // Recovery after reset, 1-cycle target.
        applyStimulus(8'h06, 32'h0, 32'h0000_1000, 1'b1, 32'h0, 1'b0);
        targetServe(8'h06, 32'h0, 32'h0000_1000, 0, 32'h7777_7777, 0);
        waitIdle();

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_cmd_master.md
DBG_CMD_MASTER -- requirements
Module: dbg_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of ACTIVE cycles waited for dut_done (used only under DBG_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port req_valid_i, input, 1 bit: a command request is present.
REQ-005 SHALL have port req_ready_o, output, 1 bit: the block accepts a request.
REQ-006 SHALL have port req_cmd_i, input, 8 bits: command code (0x01 halt, 0x02 resume, 0x03 read reg, 0x04 write reg, 0x05 read pc, 0x06 write pc).
REQ-007 SHALL have port req_addr_i, input, 32 bits: register address; only [4:0] is meaningful to the target.
REQ-008 SHALL have port req_data_i, input, 32 bits: write data.
REQ-009 SHALL have port rsp_valid_o, output, 1 bit: a response is present.
REQ-010 SHALL have port rsp_ready_i, input, 1 bit: the consumer accepts the response.
REQ-011 SHALL have port rsp_data_o, output, 32 bits: read data (register or pc).
REQ-012 SHALL have port rsp_err_o, output, 1 bit: the command was rejected or timed out.
REQ-013 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port dbg_bus, interface dbg_intf, debugger-side modport: drives cmd[7:0], addr[31:0] and data_dbg_dut[31:0]; samples dut_done and data_dut_dbg[31:0].

Function
REQ-015 SHALL implement the FSM states IDLE, ACTIVE, DRAIN and RESP.
REQ-016 SHALL hold req_ready_o=1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-017 SHALL, on accepting a valid command 0x01-0x06, register cmd, addr and data, drive them on dbg_bus from the next cycle, and enter ACTIVE.
REQ-018 SHALL, on accepting command 0x00 or any code >0x06, enter RESP with rsp_err_o=1 and rsp_data_o=0, and keep dbg_bus.cmd at 0 throughout.
REQ-019 SHALL hold dbg_bus.cmd, addr and data_dbg_dut stable for the whole of ACTIVE.
REQ-020 SHALL, in ACTIVE, when dut_done=1 is sampled: capture data_dut_dbg into rsp_data_o (commands 0x03 and 0x05 only; 0 otherwise), drive cmd=0 from the next cycle, and enter DRAIN.
REQ-021 SHALL stay in DRAIN, with cmd=0, until dut_done=0 is sampled, then enter RESP; this blocks a stale done from completing the next command.
REQ-022 SHALL hold rsp_valid_o=1 in RESP with rsp_data_o and rsp_err_o stable; on rsp_ready_i=1, return to IDLE in the next cycle.
REQ-023 SHALL support back-to-back commands, RESP -> IDLE -> accept, with a minimum of 4 cycles per command for a 1-cycle target.
REQ-024 SHALL drive dbg_bus.cmd=0, addr=0 and data_dbg_dut=0 in IDLE and RESP.

Reset
REQ-025 SHALL, while rstn_i=0 (asynchronous), force: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, dbg_bus.cmd/addr/data_dbg_dut=0, timeout counter=0.
REQ-026 SHALL, on reset asserted mid-command, discard that command with no response.

Configuration
REQ-027 SHALL, with DBG_TIMEOUT_EN defined, count ACTIVE cycles; when the count reaches TIMEOUT_CYCLES without dut_done, drive cmd=0, set rsp_err_o=1 and rsp_data_o=0, and enter DRAIN. The counter clears on entry to ACTIVE.
REQ-028 SHALL, without DBG_TIMEOUT_EN, contain no counter and wait in ACTIVE indefinitely; rsp_err_o is then set only by REQ-018.

Verification
REQ-029 SHALL cover: request 0x05, target returns data_dut_dbg=0x0000_0124 with dut_done 2 cycles later -> rsp_data_o=0x0000_0124, rsp_err_o=0.
REQ-030 SHALL cover: request 0x04, addr=5, data=0xDEADBEEF -> bus shows cmd=0x04, addr=5, data_dbg_dut=0xDEADBEEF until done; response has rsp_data_o=0, rsp_err_o=0.
REQ-031 SHALL cover: request 0x09 -> no bus activity; response has rsp_err_o=1 one cycle after acceptance.
REQ-032 SHALL cover: target holds dut_done=1 for 3 cycles after cmd drops -> FSM stays in DRAIN; a following 0x01 request completes on its own done.
REQ-033 SHALL cover: DBG_TIMEOUT_EN defined with TIMEOUT_CYCLES=8 and a target that never asserts done -> rsp_err_o=1 after 8 ACTIVE cycles; without the macro, busy_o stays 1.
REQ-034 SHALL cover: rstn_i pulsed low during ACTIVE -> outputs take reset values immediately and no response is issued.
